// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one instruction-memory request at a time,
// holds the returned word for decode, and handles redirects, flushes and halt.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        is_halt,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        drop_q, drop_d;

  logic        req_fire;
  logic [31:0] redirect_pc;
  // Low target bits are forced to zero; keep them visibly consumed.
  logic        unused_redirect_lsbs;

  assign redirect_pc          = {redirect_target[31:2], 2'b00};
  assign req_fire             = imem_req_valid && imem_req_ready;
  assign unused_redirect_lsbs = ^redirect_target[1:0];

  // State register: FSM state, fetch pc, drop flag and held instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next-state logic: sequencing, response capture/discard and pc update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (is_halt) begin
          state_d = StHalt;
        end else if (req_fire) begin
          // A redirect racing the handshake makes the in-flight word stale.
          state_d = StWait;
          drop_d  = redirect_valid;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            instr_d    = imem_resp_data;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = StHold;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        // Redirect flushes the held word even when decode is stalled.
        if (redirect_valid || !stall) begin
          state_d = StReq;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    // Redirect wins over the sequential pc+4 update.
    if (redirect_valid && (state_q != StHalt)) begin
      pc_d = redirect_pc;
    end
  end

  // Output logic: request and decode-side signals decoded from state.
  always_comb begin
    imem_req_valid = (state_q == StReq) && !is_halt;
    imem_req_addr  = pc_q;
    instr_valid    = (state_q == StHold);
    instr          = instr_q;
    instr_pc       = instr_pc_q;
    halted         = (state_q == StHalt);
  end

endmodule
